// File: rtl/cam_pkg.sv
// Shared types and default sizes for the sorted-CAM top-N read path.
package cam_pkg;

  localparam int NUM_ENTRY  = 25;
  localparam int INDEX_SIZE = 5;
  localparam int ADDR_SIZE  = 22;
  localparam int CNT_SIZE   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic [CNT_SIZE-1:0]  cnt;
    logic                 last;
  } cam_entry_t;

  function automatic logic [INDEX_SIZE:0] min3(input logic [INDEX_SIZE:0] a,
                                               input logic [INDEX_SIZE:0] b,
                                               input logic [INDEX_SIZE:0] c);
    logic [INDEX_SIZE:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/cam_rd_skid_fifo.sv
// Two-entry fall-through skid buffer for CAM read returns; exports the read credit
// so the reader never has more than two entries in flight or buffered.
module cam_rd_skid_fifo
  import cam_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  cam_entry_t i_push_data,
  input  logic       i_pop,
  output logic       o_valid,
  output cam_entry_t o_head,
  output logic       o_credit
);

  cam_entry_t r_mem [2];
  logic [1:0] r_count;
  logic       r_wr_ptr;
  logic       r_rd_ptr;

  logic w_empty;
  logic w_pop;
  logic w_bypass;
  logic w_wr;
  logic w_rd;

  assign w_empty = (r_count == 2'd0);
  assign o_valid = !w_empty || i_push;

  // Returning data is visible the same cycle when nothing is buffered.
  always_comb begin
    o_head = '0;
    if (!w_empty)   o_head = r_mem[r_rd_ptr];
    else if (i_push) o_head = i_push_data;
  end

  assign w_pop    = i_pop && o_valid;
  assign w_bypass = w_empty && i_push && w_pop;
  assign w_wr     = i_push && !w_bypass;
  assign w_rd     = w_pop && !w_empty;

  // A read may issue only if the arriving return plus stored entries leave a slot.
  assign o_credit = (({1'b0, r_count} + {2'b00, i_push}) < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_rd) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_wr} - {1'b0, w_rd};
    end
  end

endmodule

// File: rtl/cam_topk_reader.sv
// Freezes the sorted CAM and streams its top-N (addr, cnt) entries over valid/ready.
// state | meaning
// IDLE  | ready for a query, CAM free to update
// READ  | CAM frozen, issuing reads and streaming beats
// DONE  | one-cycle done pulse, CAM released
module cam_topk_reader
  import cam_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_query_valid,
  output logic                  o_query_ready,
  input  logic [INDEX_SIZE:0]   i_query_num,
  input  logic [INDEX_SIZE:0]   i_cam_occupancy,
  output logic                  o_cam_freeze,
  output logic                  o_cam_rd_en,
  output logic [INDEX_SIZE-1:0] o_cam_rd_index,
  input  logic [ADDR_SIZE-1:0]  i_cam_rd_addr,
  input  logic [CNT_SIZE-1:0]   i_cam_rd_cnt,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [ADDR_SIZE-1:0]  o_out_addr,
  output logic [CNT_SIZE-1:0]   o_out_cnt,
  output logic                  o_out_last,
  output logic                  o_done,
  output logic [INDEX_SIZE:0]   o_done_num
);

  localparam logic [INDEX_SIZE:0] ONE     = (INDEX_SIZE+1)'(1);
  localparam logic [INDEX_SIZE:0] MAX_NUM = (INDEX_SIZE+1)'(NUM_ENTRY);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [INDEX_SIZE:0] r_num_q;
  logic [INDEX_SIZE:0] r_rd_idx;
  logic [INDEX_SIZE:0] r_pend_idx;
  logic [INDEX_SIZE:0] r_sent_cnt;
  logic                r_rd_pend;

  logic [INDEX_SIZE:0] w_num_clip;
  logic                w_accept;
  logic                w_hs;
  logic                w_credit;
  cam_entry_t          w_push_entry;
  cam_entry_t          w_head;

  assign w_num_clip = min3(i_query_num, i_cam_occupancy, MAX_NUM);
  assign w_accept   = i_query_valid && o_query_ready;
  assign w_hs       = o_out_valid && i_out_ready;

  assign w_push_entry.addr = i_cam_rd_addr;
  assign w_push_entry.cnt  = i_cam_rd_cnt;
  assign w_push_entry.last = (r_pend_idx == (r_num_q - ONE));

  cam_rd_skid_fifo u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_rd_pend),
    .i_push_data (w_push_entry),
    .i_pop       (i_out_ready),
    .o_valid     (o_out_valid),
    .o_head      (w_head),
    .o_credit    (w_credit)
  );

  assign o_out_addr     = w_head.addr;
  assign o_out_cnt      = w_head.cnt;
  assign o_out_last     = w_head.last;
  assign o_cam_rd_index = r_rd_idx[INDEX_SIZE-1:0];
  assign o_done_num     = r_sent_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_query_ready = 1'b0;
    o_cam_freeze  = 1'b0;
    o_cam_rd_en   = 1'b0;
    o_done        = 1'b0;
    case (r_state)
      IDLE: begin
        o_query_ready = 1'b1;
        if (i_query_valid) w_state_nxt = (w_num_clip == '0) ? DONE : READ;
      end
      READ: begin
        o_cam_freeze = 1'b1;
        o_cam_rd_en  = (r_rd_idx < r_num_q) && w_credit;
        if (w_hs && w_head.last) w_state_nxt = DONE;
      end
      DONE: begin
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_q    <= '0;
      r_rd_idx   <= '0;
      r_pend_idx <= '0;
      r_sent_cnt <= '0;
      r_rd_pend  <= 1'b0;
    end else begin
      r_rd_pend <= o_cam_rd_en;
      if (w_accept) begin
        r_num_q    <= w_num_clip;
        r_rd_idx   <= '0;
        r_sent_cnt <= '0;
      end else begin
        if (o_cam_rd_en) begin
          r_rd_idx   <= r_rd_idx + ONE;
          r_pend_idx <= r_rd_idx;
        end
        if (w_hs) r_sent_cnt <= r_sent_cnt + ONE;
      end
    end
  end

endmodule

// File: tb/tb_cam_topk_reader.sv
// Scoreboarded bench for cam_topk_reader against a registered-read CAM model.
module tb_cam_topk_reader;

  logic        clk;
  logic        rst_n;
  logic        i_query_valid;
  logic        o_query_ready;
  logic [5:0]  i_query_num;
  logic [5:0]  i_cam_occupancy;
  logic        o_cam_freeze;
  logic        o_cam_rd_en;
  logic [4:0]  o_cam_rd_index;
  logic [21:0] i_cam_rd_addr;
  logic [31:0] i_cam_rd_cnt;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [21:0] o_out_addr;
  logic [31:0] o_out_cnt;
  logic        o_out_last;
  logic        o_done;
  logic [5:0]  o_done_num;

  cam_topk_reader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_query_valid   (i_query_valid),
    .o_query_ready   (o_query_ready),
    .i_query_num     (i_query_num),
    .i_cam_occupancy (i_cam_occupancy),
    .o_cam_freeze    (o_cam_freeze),
    .o_cam_rd_en     (o_cam_rd_en),
    .o_cam_rd_index  (o_cam_rd_index),
    .i_cam_rd_addr   (i_cam_rd_addr),
    .i_cam_rd_cnt    (i_cam_rd_cnt),
    .o_out_valid     (o_out_valid),
    .i_out_ready     (i_out_ready),
    .o_out_addr      (o_out_addr),
    .o_out_cnt       (o_out_cnt),
    .o_out_last      (o_out_last),
    .o_done          (o_done),
    .o_done_num      (o_done_num)
  );

  typedef struct {
    logic [21:0] a;
    logic [31:0] c;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_n = 0;
  int   outstanding = 0;
  logic prev_stall = 0;
  logic [21:0] prev_a;
  logic [31:0] prev_c;
  logic        prev_l;
  int   cam_a [32];
  int   cam_c [32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CAM read port: data valid exactly one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (o_cam_rd_en) begin
      i_cam_rd_addr <= 22'(cam_a[o_cam_rd_index]);
      i_cam_rd_cnt  <= 32'(cam_c[o_cam_rd_index]);
    end else begin
      i_cam_rd_addr <= 22'h2AAAA;
      i_cam_rd_cnt  <= 32'hDEADBEEF;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (o_cam_rd_en) begin
        n_checks++;
        if (int'(o_cam_rd_index) >= exp_n) begin
          n_errors++;
          $display("FAIL rd_index: issued %0d, limit %0d", o_cam_rd_index, exp_n);
        end
        n_checks++;
        if (outstanding + 1 > 2) begin
          n_errors++;
          $display("FAIL credit: in flight+buffered %0d, max 2", outstanding + 1);
        end
        outstanding++;
      end
      if (prev_stall) begin
        n_checks++;
        if (o_out_valid !== 1'b1 || o_out_addr !== prev_a || o_out_cnt !== prev_c || o_out_last !== prev_l) begin
          n_errors++;
          $display("FAIL stall_hold: got v=%0b a=%0d c=%0d l=%0b, expected v=1 a=%0d c=%0d l=%0b",
                   o_out_valid, o_out_addr, o_out_cnt, o_out_last, prev_a, prev_c, prev_l);
        end
      end
      if (o_out_valid && i_out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL extra_beat: got a=%0d c=%0d, expected no beat", o_out_addr, o_out_cnt);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (o_out_addr !== e.a || o_out_cnt !== e.c || o_out_last !== e.l) begin
            n_errors++;
            $display("FAIL beat: got a=%0d c=%0d l=%0b, expected a=%0d c=%0d l=%0b",
                     o_out_addr, o_out_cnt, o_out_last, e.a, e.c, e.l);
          end
        end
        outstanding--;
      end
      prev_stall = o_out_valid && !i_out_ready;
      prev_a = o_out_addr;
      prev_c = o_out_cnt;
      prev_l = o_out_last;
    end
  end

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic do_query(input int num, input int occ);
    int n;
    exp_t e;
    @(posedge clk); #1;
    i_query_num     = 6'(num);
    i_cam_occupancy = 6'(occ);
    i_query_valid   = 1'b1;
    n = imin(imin(num, occ), 25);
    exp_n = n;
    for (int i = 0; i < n; i++) begin
      e.a = 22'(cam_a[i]);
      e.c = 32'(cam_c[i]);
      e.l = (i == n - 1);
      sb.push_back(e);
    end
    @(negedge clk);
    n_checks++;
    if (o_query_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL accept_ready: got %0b, expected 1", o_query_ready);
    end
    @(posedge clk); #1;
    i_query_valid = 1'b0;
  endtask

  task automatic run_query(input int mode, input int occ_mid, input int poke,
                           output int first_valid, output int done_at, output int freeze_cyc,
                           output int dnum, output logic rdy_done, output logic frz_done,
                           output logic done_after, output logic rdy_k1);
    first_valid = -1; done_at = -1; freeze_cyc = 0; dnum = -1;
    rdy_done = 1'b1; frz_done = 1'b1; done_after = 1'b1; rdy_k1 = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      i_out_ready = (mode == 0) ? 1'b1 : (((k - 1) % 4 == 0) || ((k - 1) % 4 == 3));
      if (occ_mid >= 0 && k == 2) i_cam_occupancy = 6'(occ_mid);
      i_query_valid = (poke != 0) && (k <= 3);
      @(negedge clk);
      if (k == 1) rdy_k1 = o_query_ready;
      if (o_cam_freeze) freeze_cyc++;
      if (o_out_valid && first_valid < 0) first_valid = k;
      if (o_done) begin
        done_at  = k;
        dnum     = int'(o_done_num);
        rdy_done = o_query_ready;
        frz_done = o_cam_freeze;
        break;
      end
    end
    @(posedge clk); #1;
    i_query_valid = 1'b0;
    i_out_ready   = 1'b1;
    @(negedge clk);
    done_after = o_done;
    n_checks++;
    if (done_at < 0) begin
      n_errors++;
      $display("FAIL timeout: no done within 200 cycles, expected done pulse");
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (o_query_ready !== 1'b1 || o_cam_freeze !== 1'b0 || o_cam_rd_en !== 1'b0 ||
        o_out_valid !== 1'b0 || o_done !== 1'b0 || o_done_num !== 6'd0 ||
        o_out_addr !== 22'd0 || o_out_cnt !== 32'd0 || o_out_last !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got rdy=%0b frz=%0b rd=%0b v=%0b done=%0b num=%0d a=%0d, expected 1 0 0 0 0 0 0",
               o_query_ready, o_cam_freeze, o_cam_rd_en, o_out_valid, o_done, o_done_num, o_out_addr);
    end
    #7 rst_n = 1'b1;
  endtask

  task automatic test_top3();
    int fv, da, fc, dn;
    logic rd, fd, dafter, r1;
    do_query(3, 11);
    run_query(0, -1, 0, fv, da, fc, dn, rd, fd, dafter, r1);
    n_checks++; if (fv !== 2) begin n_errors++; $display("FAIL top3_first_valid: got %0d, expected 2", fv); end
    n_checks++; if (da !== 5) begin n_errors++; $display("FAIL top3_done_cycle: got %0d, expected 5", da); end
    n_checks++; if (fc !== 4) begin n_errors++; $display("FAIL top3_freeze_cycles: got %0d, expected 4", fc); end
    n_checks++; if (dn !== 3) begin n_errors++; $display("FAIL top3_done_num: got %0d, expected 3", dn); end
    n_checks++; if (fd !== 1'b0 || rd !== 1'b0) begin n_errors++; $display("FAIL top3_done_flags: got frz=%0b rdy=%0b, expected 0 0", fd, rd); end
    n_checks++; if (dafter !== 1'b0) begin n_errors++; $display("FAIL top3_done_width: got %0b, expected 0", dafter); end
    n_checks++; if (sb.size() !== 0) begin n_errors++; $display("FAIL top3_missing: got %0d left, expected 0", sb.size()); end
  endtask

  task automatic test_clip();
    int fv, da, fc, dn;
    logic rd, fd, dafter, r1;
    do_query(20, 11);
    run_query(0, 3, 0, fv, da, fc, dn, rd, fd, dafter, r1);
    n_checks++; if (dn !== 11) begin n_errors++; $display("FAIL clip_done_num: got %0d, expected 11", dn); end
    n_checks++; if (da !== 13) begin n_errors++; $display("FAIL clip_done_cycle: got %0d, expected 13", da); end
    n_checks++; if (sb.size() !== 0) begin n_errors++; $display("FAIL clip_missing: got %0d left, expected 0", sb.size()); end
    i_cam_occupancy = 6'd11;
  endtask

  task automatic test_backpressure();
    int fv, da, fc, dn;
    logic rd, fd, dafter, r1;
    do_query(5, 11);
    run_query(1, -1, 0, fv, da, fc, dn, rd, fd, dafter, r1);
    n_checks++; if (fv !== 2) begin n_errors++; $display("FAIL bp_first_valid: got %0d, expected 2", fv); end
    n_checks++; if (dn !== 5) begin n_errors++; $display("FAIL bp_done_num: got %0d, expected 5", dn); end
    n_checks++; if (sb.size() !== 0) begin n_errors++; $display("FAIL bp_missing: got %0d left, expected 0", sb.size()); end
  endtask

  task automatic test_empty_cam();
    int fv, da, fc, dn;
    logic rd, fd, dafter, r1;
    do_query(4, 0);
    run_query(0, -1, 0, fv, da, fc, dn, rd, fd, dafter, r1);
    n_checks++; if (da !== 1) begin n_errors++; $display("FAIL empty_done_cycle: got %0d, expected 1", da); end
    n_checks++; if (dn !== 0) begin n_errors++; $display("FAIL empty_done_num: got %0d, expected 0", dn); end
    n_checks++; if (fv !== -1) begin n_errors++; $display("FAIL empty_out_valid: got cycle %0d, expected none", fv); end
    n_checks++; if (fc !== 0) begin n_errors++; $display("FAIL empty_freeze: got %0d cycles, expected 0", fc); end
    i_cam_occupancy = 6'd11;
  endtask

  task automatic test_busy_ignore();
    int fv, da, fc, dn;
    logic rd, fd, dafter, r1;
    do_query(2, 11);
    run_query(0, -1, 1, fv, da, fc, dn, rd, fd, dafter, r1);
    n_checks++; if (r1 !== 1'b0) begin n_errors++; $display("FAIL busy_ready: got %0b, expected 0", r1); end
    n_checks++; if (da !== 4 || dn !== 2) begin n_errors++; $display("FAIL busy_done: got cycle %0d num %0d, expected 4 2", da, dn); end
    n_checks++; if (rd !== 1'b0) begin n_errors++; $display("FAIL busy_ready_in_done: got %0b, expected 0", rd); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_done_num !== 6'd2 || o_cam_freeze !== 1'b0 || o_query_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_hold: got num=%0d frz=%0b rdy=%0b, expected 2 0 1", o_done_num, o_cam_freeze, o_query_ready);
    end
    n_checks++; if (sb.size() !== 0) begin n_errors++; $display("FAIL busy_missing: got %0d left, expected 0", sb.size()); end
  endtask

  task automatic test_reset_midstream();
    int fv, da, fc, dn;
    int done_seen;
    logic rd, fd, dafter, r1;
    do_query(5, 11);
    i_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_out_valid !== 1'b1 || o_out_addr !== 22'd102) begin
      n_errors++;
      $display("FAIL rst_beat2: got v=%0b a=%0d, expected 1 102", o_out_valid, o_out_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_out_valid !== 1'b0 || o_cam_freeze !== 1'b0 || o_cam_rd_en !== 1'b0 || o_done !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_async: got v=%0b frz=%0b rd=%0b done=%0b, expected 0 0 0 0",
               o_out_valid, o_cam_freeze, o_cam_rd_en, o_done);
    end
    sb.delete();
    exp_n = 0;
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_done) done_seen++;
    end
    n_checks++; if (done_seen !== 0) begin n_errors++; $display("FAIL rst_no_done: got %0d pulses, expected 0", done_seen); end
    @(posedge clk); #2 rst_n = 1'b1;
    do_query(2, 11);
    run_query(0, -1, 0, fv, da, fc, dn, rd, fd, dafter, r1);
    n_checks++; if (fv !== 2 || dn !== 2) begin n_errors++; $display("FAIL rst_recover: got first %0d num %0d, expected 2 2", fv, dn); end
    n_checks++; if (sb.size() !== 0) begin n_errors++; $display("FAIL rst_missing: got %0d left, expected 0", sb.size()); end
  endtask

  initial begin
    int pa [11] = '{118, 102, 117, 128, 110, 107, 105, 106, 111, 103, 112};
    int pc [11] = '{102, 88, 70, 59, 55, 40, 31, 30, 13, 10, 8};
    for (int i = 0; i < 32; i++) begin
      cam_a[i] = (i < 11) ? pa[i] : 4000 + i;
      cam_c[i] = (i < 11) ? pc[i] : 1;
    end
    rst_n = 1'b0;
    i_query_valid = 1'b0;
    i_query_num = 6'd0;
    i_cam_occupancy = 6'd11;
    i_out_ready = 1'b1;
    test_reset();
    test_top3();
    test_clip();
    test_backpressure();
    test_empty_cam();
    test_busy_ignore();
    test_reset_midstream();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cam_topk_reader.md
Name: cam_topk_reader

Overview:
- Read-side companion to cam_top in the count-min-sketch sorted CAM.
- cam_top ingests (addr, cnt) updates and keeps entries sorted by count, with index 0 the hottest.
- On a query, this block freezes CAM updates and walks indices 0..N-1 through the CAM read port. It streams the top-N (addr, cnt) pairs to a consumer over a valid/ready interface, with full throughput under no backpressure.
- The consumer is the hot-page promotion logic.

Parameters:
- NUM_ENTRY, 25: number of CAM entries.
- INDEX_SIZE, 5: CAM index width; must satisfy 2^INDEX_SIZE >= NUM_ENTRY.
- ADDR_SIZE, 22: tracked address width.
- CNT_SIZE, 32: count width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- query_valid  input  1  request to read the top-N entries
- query_ready  output  1  high only in IDLE
- query_num  input  INDEX_SIZE+1  N requested
- cam_occupancy  input  INDEX_SIZE+1  number of valid CAM entries, from cam_top
- cam_freeze  output  1  tells cam_top to hold input_valid updates
- cam_rd_en  output  1  CAM read strobe
- cam_rd_index  output  INDEX_SIZE  CAM read index
- cam_rd_addr  input  ADDR_SIZE  read data, valid exactly 1 cycle after cam_rd_en
- cam_rd_cnt  input  CNT_SIZE  read data, valid exactly 1 cycle after cam_rd_en
- out_valid  output  1  stream valid
- out_ready  input  1  stream ready
- out_addr  output  ADDR_SIZE  streamed address
- out_cnt  output  CNT_SIZE  streamed count
- out_last  output  1  marks the final entry of the query
- done  output  1  one-cycle pulse at end of query
- done_num  output  INDEX_SIZE+1  entries delivered, held until next query

Behaviour:
- Reset: async assert forces IDLE. All outputs go to 0, except query_ready=1 (IDLE). Counters and the buffer are cleared. Reset mid-query abandons the stream silently, with no done pulse and cam_freeze dropping immediately.
- Handshakes: query accepted when query_valid & query_ready. Output beat transfers when out_valid & out_ready.
- Latched count: on query accept, num_q = min(query_num, cam_occupancy, NUM_ENTRY), sampled in the accept cycle. cam_freeze rises the cycle after accept.
- IDLE: query_ready=1; cam_freeze=0.
  - Accept with num_q==0 -> DONE, with no reads and no beats.
  - Otherwise -> READ with rd_idx=0, sent_cnt=0.
- READ: cam_freeze=1.
  - cam_rd_en asserts when rd_idx < num_q and (reads in flight + buffered beats) < 2. cam_rd_index=rd_idx, and rd_idx increments on each read.
  - Return data is written into a 2-entry FIFO skid buffer one cycle later.
  - out_* presents the FIFO head. out_last=1 iff the head's index == num_q-1.
  - Each output handshake pops the head and increments sent_cnt.
  - The handshake of the last beat -> DONE.
  - With out_ready held high this gives 1 beat/cycle. First out_valid appears 2 cycles after accept: cycle after accept issues read 0, data lands the next cycle.
  - Under backpressure the out_* values stay stable while out_valid is high. No read is issued that could overflow the buffer.
- DONE: done=1 for one cycle; done_num=sent_cnt; cam_freeze=0 in this cycle; -> IDLE next cycle. query_ready stays low in DONE, so back-to-back queries are separated by at least 1 cycle.
- Ordering: beats leave in index order 0..num_q-1, i.e. non-increasing cnt. The block neither checks nor alters ordering.
- Widths: all index and count compares are unsigned at INDEX_SIZE+1 bits. rd_idx never exceeds num_q, so there is no wrap.
- Boundaries:
  - query_num > occupancy -> clipped.
  - occupancy==0 -> immediate DONE, done_num=0.
  - query_valid while busy is ignored and not queued.
  - cam_occupancy changes mid-query have no effect.

Decomposition:
- Package cam_pkg holds:
  - the state enum {IDLE, READ, DONE};
  - a cam_entry_t struct {addr, cnt, last};
  - the shared defaults NUM_ENTRY/INDEX_SIZE/ADDR_SIZE/CNT_SIZE.
- One sub-module, cam_rd_skid_fifo: 2-deep, cam_entry_t wide, with push/pop/count. It owns buffer-occupancy accounting and exports the credit used to gate cam_rd_en.

Test Plan:
- CAM model preloaded with the sorted set (118,102) (102,88) (117,70) (128,59) (110,55) (107,40) (105,31) (106,30) (111,13) (103,10) (112,8); occupancy=11.
- query_num=3, out_ready=1 -> beats (118,102), (102,88), (117,70) on consecutive cycles, first beat 2 cycles after accept; out_last on the 3rd; done with done_num=3; cam_freeze high from accept+1 through the last beat.
- query_num=20 (occupancy 11) -> exactly 11 beats ending (112,8) with out_last; done_num=11; no cam_rd_index >= 11 ever issued.
- query_num=5, out_ready toggling 1-0-0-1 repeatedly -> no beat lost, duplicated or changed while stalled; reads in flight + buffered <= 2 at all times; order (118,102) .. (110,55).
- occupancy=0, query_num=4 -> no cam_rd_en, no out_valid; done pulse 1 cycle after accept with done_num=0.
- rst_n asserted low during beat 2 of a 5-entry query -> out_valid, cam_freeze and cam_rd_en drop asynchronously with no done pulse. After release, query_num=2 returns (118,102), (102,88) correctly.
